hostif_bram_responder: RTL

- Responder end of the SDRAM host interface (addr/din/dout/read_rq/write_rq/rfsh_rq/busy) used by the SDRAM testers and cores.
- Backed by on-chip block RAM instead of a physical SDRAM, with SDRAM-like busy timing.
- Lets testers and host FSMs run in simulation and on boards without SDRAM fitted.
- Adds protocol checking: request overrun, request collision and refresh starvation.

---
 rtl/hostif_bram_responder.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/hostif_bram_responder.sv
// SDRAM host-interface responder backed by block RAM, with SDRAM-like busy timing
// and protocol checking (overrun, collision, refresh starvation).
module hostif_bram_responder #(
  parameter int unsigned MEM_ABITS    = 12,
  parameter int unsigned INIT_CYCLES  = 100,
  parameter int unsigned READ_CYCLES  = 6,
  parameter int unsigned WRITE_CYCLES = 5,
  parameter int unsigned RFSH_CYCLES  = 8,
  parameter int unsigned RFSH_LIMIT   = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] addr,
  input  logic [15:0] din,
  output logic [15:0] dout,
  input  logic        read_rq,
  input  logic        write_rq,
  input  logic        rfsh_rq,
  output logic        busy,
  output logic        err_overrun,
  output logic        err_collision,
  output logic        rfsh_overdue,
  output logic [31:0] access_count
);

  localparam int unsigned DEPTH = 1 << MEM_ABITS;
  localparam logic [15:0] INIT_LAST = 16'(INIT_CYCLES - 1);
  localparam logic [15:0] RD_LAST   = 16'(READ_CYCLES - 1);
  localparam logic [15:0] WR_LAST   = 16'(WRITE_CYCLES - 1);
  localparam logic [15:0] RF_LAST   = 16'(RFSH_CYCLES - 1);
  localparam logic [15:0] LIMIT16   = 16'(RFSH_LIMIT);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_READ, S_WRITE, S_RFSH} state_e;

  state_e               state_q;
  logic [15:0]          cnt_q;
  logic                 busy_q;
  logic [15:0]          dout_q;
  logic [MEM_ABITS-1:0] addr_q;
  logic [15:0]          din_q;
  logic                 rd_q, wr_q, rf_q;
  logic                 err_overrun_q, err_collision_q, rfsh_overdue_q;
  logic [15:0]          rfsh_cnt_q, rfsh_cnt_d;
  logic [31:0]          acc_cnt_q;

  logic [15:0] mem [0:DEPTH-1];

  // Upper address bits alias onto the stored range and are deliberately ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[23:MEM_ABITS];

  logic rd_rise, wr_rise, rf_rise, any_rise, collide, overrun, idle;
  logic acc_rd, acc_wr, acc_rf, acc_any, cnt_last;

  assign rd_rise  = read_rq  & ~rd_q;
  assign wr_rise  = write_rq & ~wr_q;
  assign rf_rise  = rfsh_rq  & ~rf_q;
  assign any_rise = rd_rise | wr_rise | rf_rise;
  assign collide  = (rd_rise & wr_rise) | (rd_rise & rf_rise) | (wr_rise & rf_rise);
  assign idle     = (state_q == S_IDLE);
  assign overrun  = any_rise & ~idle;

  // Priority rfsh > write > read; losers are simply dropped.
  assign acc_rf  = idle & rf_rise;
  assign acc_wr  = idle & wr_rise & ~rf_rise;
  assign acc_rd  = idle & rd_rise & ~wr_rise & ~rf_rise;
  assign acc_any = acc_rf | acc_wr | acc_rd;

  always_comb begin
    cnt_last = 1'b0;
    case (state_q)
      S_READ:  cnt_last = (cnt_q == RD_LAST);
      S_WRITE: cnt_last = (cnt_q == WR_LAST);
      S_RFSH:  cnt_last = (cnt_q == RF_LAST);
      default: cnt_last = 1'b0;
    endcase
  end

  always_comb begin
    rfsh_cnt_d = rfsh_cnt_q;
    if (acc_rf)
      rfsh_cnt_d = '0;
    else if ((acc_rd | acc_wr) && (rfsh_cnt_q != 16'hFFFF))
      rfsh_cnt_d = rfsh_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_INIT;
      cnt_q           <= '0;
      busy_q          <= 1'b1;
      dout_q          <= '0;
      addr_q          <= '0;
      din_q           <= '0;
      rd_q            <= 1'b0;
      wr_q            <= 1'b0;
      rf_q            <= 1'b0;
      err_overrun_q   <= 1'b0;
      err_collision_q <= 1'b0;
      rfsh_overdue_q  <= 1'b0;
      rfsh_cnt_q      <= '0;
      acc_cnt_q       <= '0;
    end else begin
      rd_q       <= read_rq;
      wr_q       <= write_rq;
      rf_q       <= rfsh_rq;
      rfsh_cnt_q <= rfsh_cnt_d;
      if (overrun)              err_overrun_q   <= 1'b1;
      if (collide)              err_collision_q <= 1'b1;
      if (rfsh_cnt_d > LIMIT16) rfsh_overdue_q  <= 1'b1;
      if (acc_rd | acc_wr)      acc_cnt_q       <= acc_cnt_q + 32'd1;
      case (state_q)
        S_INIT: begin
          if (cnt_q == INIT_LAST) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_IDLE: begin
          if (acc_any) begin
            state_q <= acc_rf ? S_RFSH : (acc_wr ? S_WRITE : S_READ);
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            addr_q  <= addr[MEM_ABITS-1:0];
            din_q   <= din;
          end
        end
        default: begin
          if (cnt_last) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            if (state_q == S_READ) dout_q <= mem[addr_q];
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
      endcase
    end
  end

  // Write commits on the final WRITE cycle so a reset mid-access leaves memory intact.
  always_ff @(posedge clk) begin
    if (state_q == S_WRITE && cnt_last)
      mem[addr_q] <= din_q;
  end

  assign dout          = dout_q;
  assign busy          = busy_q;
  assign err_overrun   = err_overrun_q;
  assign err_collision = err_collision_q;
  assign rfsh_overdue  = rfsh_overdue_q;
  assign access_count  = acc_cnt_q;

endmodule
